regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port of the multi-cycle core between N write sources, for example ALU result, load data and link/writeback.
- Arbitrates with a round-robin pointer and registers the winning address/data onto the write port.
- Returns a one-cycle ack to the winner.
- Sits between the datapath result sources and the register-file write inputs.

---
 rtl/regfile_write_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port of the multi-cycle core between
// N result sources (ALU, load data, link/writeback, ...). The sources are
// served in round-robin order. The winning address and data are registered
// onto the write port, and the winner gets a one-cycle ack.
//
// Optional build macro: ARB_LOCK_EN
//   Adds the per-requester lock input and the LOCKED state. A locked owner
//   keeps the port and can write on every cycle. When the macro is undefined,
//   the block is pure round-robin.
//
// Parameters
//   W  data width of one register write
//   A  register address width
//   N  number of requesters (N >= 2)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   req       per-requester write request (level, held until acked)
//   wr_data   flat data bus; requester i drives [i*W +: W]
//   wr_addr   flat address bus; requester i drives [i*A +: A]
//   lock      per-requester hold-port request (ARB_LOCK_EN only)
//   ack       one-hot, one cycle, marks whose write is on the port
//   rf_write  register-file write enable
//   rf_addr   register-file write address (holds after the last grant)
//   rf_data   register-file write data (holds after the last grant)
//   busy      same as rf_write
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int W = 32,
  parameter int A = 4,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wr_data,
  input  logic [N*A-1:0] wr_addr,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   ack,
  output logic           rf_write,
  output logic [A-1:0]   rf_addr,
  output logic [W-1:0]   rf_data,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PW:0]   NUM  = (PW+1)'(N);
  localparam logic [PW-1:0] LAST = PW'(N-1);
  localparam logic [PW-1:0] PONE = PW'(1);

`ifdef ARB_LOCK_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCKED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT} state_t;
`endif

  // Registered state and outputs
  state_t        state_q;
  logic [PW-1:0] ptr_q;
  logic [N-1:0]  ack_q;
  logic          rf_write_q;
  logic [A-1:0]  rf_addr_q;
  logic [W-1:0]  rf_data_q;
`ifdef ARB_LOCK_EN
  logic [PW-1:0] owner_q;
`endif

  // Combinational selection
  logic [N-1:0]   ack_mask;
  logic [N-1:0]   eff;
  logic [2*N-1:0] eff2;
  logic [N-1:0]   eff_rot;
  logic           rr_found;
  logic [PW:0]    rr_off;
  logic [PW:0]    rr_sum;
  logic [PW-1:0]  rr_g;
  logic           win_found;
  logic [PW-1:0]  win_g;
  logic           win_lock;
  logic [N-1:0]   win_oh;
  logic [A-1:0]   sel_addr;
  logic [W-1:0]   sel_data;
  logic [PW-1:0]  ptr_d;

  // A request is consumed by its own ack. The requester updates req/data
  // during the ack cycle, so that cycle's req must not win a second time.
  // ack_q is always zero in IDLE, so the mask only matters after a grant.
  assign ack_mask = (state_q == S_IDLE) ? '0 : ack_q;
  assign eff      = req & ~ack_mask;

  // Rotate the request vector so that bit 0 is the ptr position. The
  // lowest set bit of the rotated vector is the round-robin winner's offset.
  assign eff2    = {eff, eff};
  assign eff_rot = N'(eff2 >> ptr_q);

  always_comb begin
    rr_found = 1'b0;
    rr_off   = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (eff_rot[k]) begin
        rr_found = 1'b1;
        rr_off   = k[PW:0];
      end
    end
    rr_sum = {1'b0, ptr_q} + rr_off;
    rr_g   = (rr_sum >= NUM) ? PW'(rr_sum - NUM) : PW'(rr_sum);
  end

  // Final winner. A locked owner that still wants the port bypasses both
  // the round-robin scan and the ack mask. Any other case falls back to
  // round-robin. ptr_q already holds owner+1 from the owner's last grant.
  always_comb begin
    win_found = rr_found;
    win_g     = rr_g;
    win_lock  = 1'b0;
`ifdef ARB_LOCK_EN
    if (state_q == S_LOCKED && req[owner_q] && lock[owner_q]) begin
      win_found = 1'b1;
      win_g     = owner_q;
    end
    win_lock = win_found & lock[win_g];
`endif
  end

  // Winner's address and data, plus the one-hot ack
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    win_oh   = '0;
    for (int i = 0; i < N; i++) begin
      if (win_g == PW'(i)) begin
        sel_addr  = wr_addr[i*A +: A];
        sel_data  = wr_data[i*W +: W];
        win_oh[i] = win_found;
      end
    end
  end

  assign ptr_d = (win_g == LAST) ? '0 : win_g + PONE;

  // Single FSM. All port outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      ack_q      <= '0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
`ifdef ARB_LOCK_EN
      owner_q    <= '0;
`endif
    end else if (win_found) begin
      ack_q      <= win_oh;
      rf_write_q <= 1'b1;
      rf_addr_q  <= sel_addr;
      rf_data_q  <= sel_data;
      ptr_q      <= ptr_d;
`ifdef ARB_LOCK_EN
      owner_q    <= win_g;
      state_q    <= win_lock ? S_LOCKED : S_GRANT;
`else
      state_q    <= win_lock ? S_IDLE : S_GRANT;
`endif
    end else begin
      // No winner: drop the strobe, but keep the last address and data.
      ack_q      <= '0;
      rf_write_q <= 1'b0;
      state_q    <= S_IDLE;
    end
  end

  assign ack      = ack_q;
  assign rf_write = rf_write_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;
  assign busy     = rf_write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for regfile_write_arbiter.
//
// The inputs for each edge are driven before that edge. At the same time a
// behavioural model computes the outputs expected after the edge and pushes
// them to a scoreboard queue. After the edge the entry is popped and
// compared. Requesters react to the model's acks, not the DUT's. Fixed
// checks for the test-plan scenarios are added on top.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
  localparam int W = 32;
  localparam int A = 4;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wr_data;
  logic [N*A-1:0] wr_addr;
  logic [N-1:0]   lock;
  logic [N-1:0]   ack;
  logic           rf_write;
  logic [A-1:0]   rf_addr;
  logic [W-1:0]   rf_data;
  logic           busy;

  regfile_write_arbiter #(.W(W), .A(A), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .ack      (ack),
    .rf_write (rf_write),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ack;
    logic         wr;
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Model state
  int           m_ptr;
  logic [N-1:0] m_ack;
  logic         m_wr;
  logic [A-1:0] m_addr;
  logic [W-1:0] m_data;
  bit           m_locked;
  int           m_owner;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Outputs expected after the next edge, given the inputs as driven now
  task automatic model_eval(output exp_t e);
    int g;
    if (reset) begin
      m_ptr = 0; m_ack = '0; m_wr = 1'b0; m_addr = '0; m_data = '0;
      m_locked = 0; m_owner = 0;
    end else begin
      g = -1;
`ifdef ARB_LOCK_EN
      if (m_locked && req[m_owner] && lock[m_owner]) g = m_owner;
`endif
      if (g < 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (g < 0 && req[i] && !m_ack[i]) g = i;
        end
      end
      if (g >= 0) begin
        m_ack   = N'(1) << g;
        m_wr    = 1'b1;
        m_addr  = wr_addr[g*A +: A];
        m_data  = wr_data[g*W +: W];
        m_ptr   = (g + 1) % N;
        m_owner = g;
`ifdef ARB_LOCK_EN
        m_locked = lock[g];
`else
        m_locked = 0;
`endif
      end else begin
        m_ack = '0;
        m_wr = 1'b0;
        m_locked = 0;
      end
    end
    e.ack = m_ack; e.wr = m_wr; e.addr = m_addr; e.data = m_data;
  endtask

  task automatic tick();
    exp_t e;
    model_eval(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("ack",      64'(ack),      64'(e.ack));
    chk("rf_write", 64'(rf_write), 64'(e.wr));
    chk("rf_addr",  64'(rf_addr),  64'(e.addr));
    chk("rf_data",  64'(rf_data),  64'(e.data));
    chk("busy",     64'(busy),     64'(e.wr));
  endtask

  task automatic set_src(input int i, input logic [A-1:0] a, input logic [W-1:0] d);
    wr_addr[i*A +: A] = a;
    wr_data[i*W +: W] = d;
  endtask

  // Requesters selected by mask drop req once their ack is seen
  task automatic drop_acked(input logic [N-1:0] mask);
    req = req & ~(m_ack & mask);
  endtask

  initial begin
    reset = 1'b1; req = '0; lock = '0; wr_data = '0; wr_addr = '0;
    m_ptr = 0; m_ack = '0; m_wr = 0; m_addr = '0; m_data = '0; m_locked = 0; m_owner = 0;

    // Reset held two cycles with every request active
    set_src(0, 4'd1, 32'h1111_0000);
    set_src(1, 4'd2, 32'h2222_0000);
    set_src(2, 4'd15, 32'h3333_0000);
    req = '1;
    tick();
    tick();
    chk("rst_rf_write", 64'(rf_write), 64'd0);
    chk("rst_rf_data",  64'(rf_data),  64'd0);
    reset = 1'b0;

    // All three requests: grants 0, 1, 2 in turn, then the pointer wraps
    tick();
    chk("rr_first_g0", 64'(ack), 64'b001);
    drop_acked('1);
    tick();
    chk("rr_g1", 64'(ack), 64'b010);
    drop_acked('1);
    tick();
    chk("rr_g2_addr15", 64'(rf_addr), 64'd15);
    drop_acked('1);
    tick();
    chk("rr_idle", 64'(rf_write), 64'd0);

    // Single write on requester 1; it drops req when it sees the ack
    set_src(1, 4'd5, 32'hDEAD_BEEF);
    req = 3'b010;
    tick();
    chk("single_ack",  64'(ack),     64'b010);
    chk("single_addr", 64'(rf_addr), 64'd5);
    chk("single_data", 64'(rf_data), 64'hDEAD_BEEF);
    drop_acked('1);
    tick();
    chk("single_wr_off", 64'(rf_write), 64'd0);
    chk("single_hold",   64'(rf_data),  64'hDEAD_BEEF);
    tick();

    // req[0] and req[2] held: grants alternate 0,2,0,2
    reset = 1'b1; tick(); reset = 1'b0;
    req = 3'b101;
    tick(); chk("alt_0a", 64'(ack), 64'b001);
    tick(); chk("alt_2a", 64'(ack), 64'b100);
    tick(); chk("alt_0b", 64'(ack), 64'b001);
    tick(); chk("alt_2b", 64'(ack), 64'b100);
    // req[2] alone and never dropped: one grant every other cycle
    req = 3'b100;
    tick(); chk("solo_gap", 64'(rf_write), 64'd0);
    tick(); chk("solo_hit", 64'(ack), 64'b100);
    tick(); chk("solo_gap2", 64'(rf_write), 64'd0);
    tick();

    // Reset asserted in the cycle after a grant
    reset = 1'b1; tick(); reset = 1'b0;
    req = 3'b010;
    tick(); chk("mid_grant", 64'(ack), 64'b010);
    reset = 1'b1;
    tick();
    chk("mid_rst_wr",  64'(rf_write), 64'd0);
    chk("mid_rst_ack", 64'(ack),      64'd0);
    reset = 1'b0;
    tick(); chk("mid_re_present", 64'(ack), 64'b010);
    drop_acked('1);
    tick();

`ifdef ARB_LOCK_EN
    // Locked owner writes on every cycle, then releases to requester 1
    reset = 1'b1; tick(); reset = 1'b0;
    req = 3'b011; lock = 3'b001;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("lock_own", 64'(ack), 64'b001);
    end
    lock = '0;
    tick(); chk("lock_release", 64'(ack), 64'b010);
    drop_acked('1);
    req = '0;
    tick();
`endif

    // Random traffic with drop-on-ack requesters
    for (int c = 0; c < 60; c++) begin
      drop_acked('1);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_src(i, A'($urandom_range(0, 15)), $urandom);
          req[i] = 1'b1;
        end
      end
`ifdef ARB_LOCK_EN
      lock = N'($urandom_range(0, 7)) & N'($urandom_range(0, 7));
`endif
      if (c == 30) reset = 1'b1;
      tick();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
